adder_seq_ctrl: RTL and testbench
=================================

// Module: adder_seq_ctrl
// PURPOSE
//  Sequencer that runs one shared combinational adder_32 over several cycles to add
//  WORDS*32-bit operands, least-significant word first, with carry chained between words.
//  Sits between a requester (start/busy/done handshake) and one adder_32 instance.
//  Operands are latched at start, so the requester may change them during the run.
// PARAMETERS
//  WORDS  4  number of 32-bit words per operand (>=2); operand width W = WORDS*32
// PORTS
//  clk         in   1     rising-edge clock
//  rst_n       in   1     asynchronous active-low reset
//  start       in   1     request; accepted only on an edge where busy==0
//  a           in   W     operand A, sampled on the accepting edge
//  b           in   W     operand B, sampled on the accepting edge
//  cin         in   1     carry into word 0, sampled on the accepting edge
//  busy        out  1     operation in progress
//  done        out  1     one-cycle pulse: result, cout and ovf are valid
//  result      out  W     sum; holds its value until the next accepted start
//  cout        out  1     carry out of the top word
//  ovf         out  1     two's-complement overflow of the full W-bit add
//  adder_x     out  32    to adder_32 x
//  adder_y     out  32    to adder_32 y
//  adder_cin   out  1     to adder_32 cin
//  adder_sum   in   32    from adder_32 sum (combinational)
//  adder_cout  in   1     from adder_32 cout (combinational)
// BEHAVIOUR
//  - Reset (async on rst_n=0): state=IDLE; busy, done, result, cout, ovf, idx and carry all 0.
//    A reset mid-run aborts the operation: no done pulse, result cleared.
//  - FSM states: IDLE and RUN.
//    IDLE: on an edge with start=1, latch a, b and carry<=cin; set idx=0, busy=1, go to RUN.
//      On the same edge clear result, cout and ovf. done drops to 0.
//    RUN: each edge writes result[32*idx+:32] <= adder_sum and carry <= adder_cout,
//      then idx <= idx+1. On the edge where idx==WORDS-1: cout <= adder_cout,
//      ovf <= (a_msb==b_msb) && (adder_sum[31]!=a_msb), busy <= 0, done <= 1, go to IDLE.
//  - Adder drive is combinational from registered state.
//    In RUN: adder_x = a_q[32*idx+:32], adder_y = b_q[32*idx+:32], adder_cin = carry.
//    In IDLE: adder_x, adder_y and adder_cin are all 0.
//  - Latency: start accepted at edge T0 -> word i written at edge T0+1+i.
//    busy=1 from T0 up to edge T0+WORDS. done=1 for exactly one cycle after edge T0+WORDS.
//  - done is cleared on the next edge unless a new completion occurs; it is never high two cycles running.
//  - Start while busy is ignored; the run and its latched operands are unaffected.
//  - Back-to-back: start=1 during the done cycle is accepted (busy==0). The new run
//    begins, and result is cleared on that edge.
//  - Arithmetic is unsigned modulo 2^W. idx is $clog2(WORDS) bits wide and resets to 0 each run.
// TESTING (WORDS=4)
//  1 a=1, b=1, cin=0, pulse start -> done exactly 4 edges later; result=2, cout=0, ovf=0.
//  2 a=2^128-1, b=1, cin=0 -> result=0, cout=1, ovf=0. Carry is seen on adder_cin for words 1..3.
//  3 a=0, b=0, cin=1 -> result=1, cout=0; second start with a=5000, b=10207, cin=1 -> result=15208.
//  4 a=0x7FFF..FF, b=1 -> result=0x8000..00, ovf=1, cout=0.
//    Start held high and a/b changed while busy -> ignored; result is unchanged.
//  5 rst_n=0 after word 2 is written -> busy, done, result, cout and ovf are 0 immediately.
//    No done pulse follows; a subsequent start completes correctly.
//  6 start held 1 continuously -> runs back-to-back; done pulses every 5th cycle.
//    Each result matches a reference model, checked over 200 random operand sets.

Source files
------------

// File: rtl/adder_seq_ctrl.sv
// adder_seq_ctrl: runs one shared 32-bit combinational adder over WORDS cycles
// to add two WORDS*32-bit operands, least-significant word first, chaining the
// carry between words. Operands are captured when a request is accepted, so the
// requester is free to change them while the run is in progress.
module adder_seq_ctrl #(
  parameter int unsigned WORDS = 4,
  localparam int unsigned W     = WORDS * 32,
  localparam int unsigned IDX_W = (WORDS > 1) ? $clog2(WORDS) : 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         cin,
  output logic         busy,
  output logic         done,
  output logic [W-1:0] result,
  output logic         cout,
  output logic         ovf,
  output logic [31:0]  adder_x,
  output logic [31:0]  adder_y,
  output logic         adder_cin,
  input  logic [31:0]  adder_sum,
  input  logic         adder_cout
);

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_e;

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WORDS - 1);

  state_e             state_q, state_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic               carry_q, carry_d;
  logic [W-1:0]       a_q, a_d;
  logic [W-1:0]       b_q, b_d;
  logic [W-1:0]       result_q, result_d;
  logic               cout_q, cout_d;
  logic               ovf_q, ovf_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;

  // Drive the shared adder from registered state only; it is idle-zero outside RUN.
  always_comb begin
    adder_x   = '0;
    adder_y   = '0;
    adder_cin = 1'b0;
    if (state_q == RUN) begin
      adder_x   = a_q[32*idx_q +: 32];
      adder_y   = b_q[32*idx_q +: 32];
      adder_cin = carry_q;
    end
  end

  // Next-state and datapath updates for the IDLE/RUN sequencer.
  always_comb begin
    // NOTE: every *_d gets a default before the case so no path leaves a
    // signal unassigned; that is what keeps this block free of latches.
    state_d  = state_q;
    idx_d    = idx_q;
    carry_d  = carry_q;
    a_d      = a_q;
    b_d      = b_q;
    result_d = result_q;
    cout_d   = cout_q;
    ovf_d    = ovf_q;
    busy_d   = busy_q;
    done_d   = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (start) begin
          a_d      = a;
          b_d      = b;
          carry_d  = cin;
          idx_d    = '0;
          busy_d   = 1'b1;
          result_d = '0;
          cout_d   = 1'b0;
          ovf_d    = 1'b0;
          state_d  = RUN;
        end
      end
      RUN: begin
        result_d[32*idx_q +: 32] = adder_sum;
        carry_d                  = adder_cout;
        idx_d                    = idx_q + 1'b1;
        if (idx_q == LAST_IDX) begin
          // Overflow: operands share a sign and the top sum bit disagrees with it.
          cout_d  = adder_cout;
          ovf_d   = (a_q[W-1] == b_q[W-1]) && (adder_sum[31] != a_q[W-1]);
          busy_d  = 1'b0;
          done_d  = 1'b1;
          idx_d   = '0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State register; an asynchronous reset aborts any run in progress.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: the operand latches are plain registers, not a memory array, so
      // they are reset with everything else to keep the block fully defined.
      state_q  <= IDLE;
      idx_q    <= '0;
      carry_q  <= 1'b0;
      a_q      <= '0;
      b_q      <= '0;
      result_q <= '0;
      cout_q   <= 1'b0;
      ovf_q    <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples pre-edge values.
      state_q  <= state_d;
      idx_q    <= idx_d;
      carry_q  <= carry_d;
      a_q      <= a_d;
      b_q      <= b_d;
      result_q <= result_d;
      cout_q   <= cout_d;
      ovf_q    <= ovf_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  assign busy   = busy_q;
  assign done   = done_q;
  assign result = result_q;
  assign cout   = cout_q;
  assign ovf    = ovf_q;

endmodule

// File: tb/tb_adder_seq_ctrl.sv
// Directed testbench for adder_seq_ctrl with WORDS=4; the 32-bit adder is
// modelled here as a plain combinational add.
module tb_adder_seq_ctrl;

  localparam int WORDS = 4;
  localparam int W     = WORDS * 32;

  typedef logic [W:0] cv_t;

  logic         clk   = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic         cin   = 1'b0;
  logic [W-1:0] a     = '0;
  logic [W-1:0] b     = '0;
  logic         busy, done, cout, ovf;
  logic [W-1:0] result;
  logic [31:0]  adder_x, adder_y, adder_sum;
  logic         adder_cin, adder_cout;

  adder_seq_ctrl #(.WORDS(WORDS)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .a          (a),
    .b          (b),
    .cin        (cin),
    .busy       (busy),
    .done       (done),
    .result     (result),
    .cout       (cout),
    .ovf        (ovf),
    .adder_x    (adder_x),
    .adder_y    (adder_y),
    .adder_cin  (adder_cin),
    .adder_sum  (adder_sum),
    .adder_cout (adder_cout)
  );

  assign {adder_cout, adder_sum} = {1'b0, adder_x} + {1'b0, adder_y} + {32'd0, adder_cin};

  always #5 clk = ~clk;

  int               n_checks = 0;
  int               n_pass   = 0;
  int               lat;
  logic [WORDS-1:0] cin_seen;

  task automatic check(input string tag, input cv_t got, input cv_t exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  // Issue one request, then wait (bounded) for done; records adder_cin per word.
  task automatic run_op(input logic [W-1:0] ta, input logic [W-1:0] tb_v, input logic tc);
    int k;
    @(negedge clk);
    a = ta; b = tb_v; cin = tc; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("busy_after_start", cv_t'(busy), cv_t'(1));
    check("result_cleared", cv_t'(result), cv_t'(0));
    lat = 0;
    k = 0;
    cin_seen = '0;
    while (!done && lat < 20) begin
      if (busy && k < WORDS) begin
        cin_seen[k] = adder_cin;
        k++;
      end
      @(negedge clk);
      lat++;
    end
    check("latency", cv_t'(lat), cv_t'(4));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [W-1:0] ta, tb_v, exp_sum;
    logic         tc, exp_cout, exp_ovf;
    int           pulses, gap;

    // Reset state
    #1;
    check("rst_busy", cv_t'(busy), cv_t'(0));
    check("rst_done", cv_t'(done), cv_t'(0));
    check("rst_result", cv_t'(result), cv_t'(0));
    check("rst_adder_x", cv_t'(adder_x), cv_t'(0));
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    // 1: 1 + 1
    run_op(128'd1, 128'd1, 1'b0);
    check("t1_done", cv_t'(done), cv_t'(1));
    check("t1_result", cv_t'(result), cv_t'(2));
    check("t1_cout", cv_t'(cout), cv_t'(0));
    check("t1_ovf", cv_t'(ovf), cv_t'(0));
    @(negedge clk);
    check("t1_done_pulse", cv_t'(done), cv_t'(0));
    check("t1_result_hold", cv_t'(result), cv_t'(2));

    // 2: all-ones + 1 ripples a carry through every word
    run_op({W{1'b1}}, 128'd1, 1'b0);
    check("t2_result", cv_t'(result), cv_t'(0));
    check("t2_cout", cv_t'(cout), cv_t'(1));
    check("t2_ovf", cv_t'(ovf), cv_t'(0));
    check("t2_carry_chain", cv_t'(cin_seen), cv_t'(4'b1110));

    // 3: carry-in only, then a second independent request
    run_op(128'd0, 128'd0, 1'b1);
    check("t3a_result", cv_t'(result), cv_t'(1));
    check("t3a_cout", cv_t'(cout), cv_t'(0));
    run_op(128'd5000, 128'd10207, 1'b1);
    check("t3b_result", cv_t'(result), cv_t'(15208));

    // 4: signed overflow, with start held and operands changed while busy
    @(negedge clk);
    a = {1'b0, {(W-1){1'b1}}}; b = 128'd1; cin = 1'b0; start = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      a = {4{32'hdeadbeef}};
      b = {4{32'h12345678}};
      cin = 1'b1;
      check("t4_busy", cv_t'(busy), cv_t'(1));
    end
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    check("t4_done", cv_t'(done), cv_t'(1));
    check("t4_result", cv_t'(result), cv_t'({1'b1, {(W-1){1'b0}}}));
    check("t4_ovf", cv_t'(ovf), cv_t'(1));
    check("t4_cout", cv_t'(cout), cv_t'(0));
    @(negedge clk);
    check("t4_idle", cv_t'(busy), cv_t'(0));
    check("t4_result_hold", cv_t'(result), cv_t'({1'b1, {(W-1){1'b0}}}));

    // 5: reset after word 2 is written aborts the run
    @(negedge clk);
    a = {4{32'h11111111}}; b = {4{32'h22222222}}; cin = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    @(negedge clk);
    check("t5_partial", cv_t'(result), cv_t'({32'd0, {3{32'h33333333}}}));
    rst_n = 1'b0;
    #1;
    check("t5_busy", cv_t'(busy), cv_t'(0));
    check("t5_done", cv_t'(done), cv_t'(0));
    check("t5_result", cv_t'(result), cv_t'(0));
    check("t5_cout", cv_t'(cout), cv_t'(0));
    check("t5_ovf", cv_t'(ovf), cv_t'(0));
    @(negedge clk);
    rst_n = 1'b1;
    pulses = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (done) pulses++;
    end
    check("t5_no_done", cv_t'(pulses), cv_t'(0));
    run_op(128'd3, 128'd4, 1'b0);
    check("t5_after", cv_t'(result), cv_t'(7));

    // 6: start held high, back-to-back runs against a reference sum
    @(negedge clk);
    ta = {$urandom, $urandom, $urandom, $urandom};
    tb_v = {$urandom, $urandom, $urandom, $urandom};
    tc = 1'($urandom);
    a = ta; b = tb_v; cin = tc; start = 1'b1;
    for (int n = 0; n < 200; n++) begin
      {exp_cout, exp_sum} = {1'b0, ta} + {1'b0, tb_v} + {{W{1'b0}}, tc};
      exp_ovf = (ta[W-1] == tb_v[W-1]) && (exp_sum[W-1] != ta[W-1]);
      @(negedge clk);
      check("t6_busy", cv_t'(busy), cv_t'(1));
      gap = 1;
      while (!done && gap < 20) begin
        @(negedge clk);
        gap++;
      end
      check("t6_period", cv_t'(gap), cv_t'(5));
      check("t6_sum", {cout, result}, {exp_cout, exp_sum});
      check("t6_ovf", cv_t'(ovf), cv_t'(exp_ovf));
      ta = {$urandom, $urandom, $urandom, $urandom};
      tb_v = {$urandom, $urandom, $urandom, $urandom};
      tc = 1'($urandom);
      a = ta; b = tb_v; cin = tc;
    end
    start = 1'b0;
    @(negedge clk);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
